// File: rtl/seq_divider_pkg.sv
// Shared types and sizing helpers for the iterative restoring divider.
package seq_divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned DEF_WIDTH = 8;

   // Counter must hold the value WIDTH itself
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

   localparam int unsigned DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, try to subtract the divisor.
module div_step
   import seq_divider_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic             i_bit,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_qbit
);

   logic [WIDTH:0] w_trial;
   logic [WIDTH:0] w_diff;

   assign w_trial = {i_rem, i_bit};
   assign w_diff  = w_trial - {1'b0, i_divisor};

   // Borrow out of the top bit means the subtraction must be undone
   always_comb begin
      o_qbit = ~w_diff[WIDTH];
      o_rem  = w_diff[WIDTH] ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0];
   end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, results held until the next completion.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CNT_W = cnt_width(WIDTH);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic             w_accept;
   logic             w_div_zero;
   logic             w_last;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_dq;
   logic [WIDTH-1:0] r_divisor;
   logic [WIDTH-1:0] w_rem;
   logic             w_qbit;

   assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_div_zero = (divisor == '0);
   assign w_last     = (r_cnt == CNT_W'(1));

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem     (r_rem),
      .i_bit     (r_dq[WIDTH-1]),
      .i_divisor (r_divisor),
      .o_rem     (w_rem),
      .o_qbit    (w_qbit)
   );

   // State register and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         busy    <= w_busy_nxt;
         done    <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE, DONE: begin
            if (start) w_state_nxt = w_div_zero ? DONE : RUN;
            else       w_state_nxt = IDLE;
         end
         RUN:     if (w_last) w_state_nxt = DONE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_busy_nxt = 1'b0;
      w_done_nxt = 1'b0;
      w_busy_nxt = (w_state_nxt == RUN);
      w_done_nxt = (w_state_nxt == DONE);
   end

   // Dividend bits leave r_dq at the top while quotient bits enter at the bottom
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_rem       <= '0;
         r_dq        <= '0;
         r_divisor   <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (w_accept) begin
         if (w_div_zero) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
         end else begin
            r_divisor <= divisor;
            r_dq      <= dividend;
            r_rem     <= '0;
            r_cnt     <= CNT_W'(WIDTH);
         end
      end else if (r_state == RUN) begin
         r_rem <= w_rem;
         r_dq  <= {r_dq[WIDTH-2:0], w_qbit};
         r_cnt <= r_cnt - CNT_W'(1);
         if (w_last) begin
            quotient    <= {r_dq[WIDTH-2:0], w_qbit};
            remainder   <= w_rem;
            div_by_zero <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=8): vector table plus hand-written multi-cycle sequences.
module tb_seq_divider;

   localparam int unsigned W = 8;

   typedef struct {
      logic [W-1:0] dd;
      logic [W-1:0] dv;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int n_vec = 0;
   int n_err = 0;
   int prev_q = 0;
   int prev_r = 0;

   vec_t vecs[10];

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Caller is at a negedge; start is sampled at the following posedge
   task automatic start_op(input int dd, input int dv);
      start    = 1'b1;
      dividend = W'(dd);
      divisor  = W'(dv);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Count negedges after the start edge until done; lat=0 means it never came
   task automatic wait_done(input int hq, input int hr,
                            output int lat, output int nbusy, output int nchg);
      lat = 0; nbusy = 0; nchg = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (busy) nbusy++;
         if (done) begin
            lat = k;
            break;
         end
         if (int'(quotient) != hq || int'(remainder) != hr) nchg++;
      end
   endtask

   task automatic do_op(input string name, input vec_t v);
      int lat, nb, nchg;
      @(negedge clk);
      start_op(int'(v.dd), int'(v.dv));
      wait_done(prev_q, prev_r, lat, nb, nchg);
      check({name, " latency"}, lat, (v.dv == 0) ? 1 : W + 1);
      check({name, " busy cycles"}, nb, (v.dv == 0) ? 0 : W);
      check({name, " held before done"}, nchg, 0);
      check({name, " quotient"}, int'(quotient), int'(v.q));
      check({name, " remainder"}, int'(remainder), int'(v.r));
      check({name, " div_by_zero"}, int'(div_by_zero), int'(v.z));
      @(negedge clk);
      check({name, " done single pulse"}, int'(done), 0);
      check({name, " result kept"}, int'(quotient), int'(v.q));
      prev_q = int'(v.q);
      prev_r = int'(v.r);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1);
   end

   initial begin
      int lat, nb, nchg, ndone;
      vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0};
      vecs[1] = '{8'd5,   8'd0,   8'd255, 8'd5,   1'b1};
      vecs[2] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
      vecs[3] = '{8'd3,   8'd10,  8'd0,   8'd3,   1'b0};
      vecs[4] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
      vecs[5] = '{8'd0,   8'd3,   8'd0,   8'd0,   1'b0};
      vecs[6] = '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1};
      vecs[7] = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0};
      vecs[8] = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0};
      vecs[9] = '{8'd17,  8'd4,   8'd4,   8'd1,   1'b0};

      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(posedge clk);
      // Start with a zero divisor while reset is held must be ignored
      @(negedge clk);
      start = 1'b1; dividend = 8'd5; divisor = 8'd0;
      @(negedge clk);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset quotient", int'(quotient), 0);
      check("reset remainder", int'(remainder), 0);
      check("reset div_by_zero", int'(div_by_zero), 0);
      start = 1'b0;
      rst = 1'b0;

      for (int i = 0; i < 10; i++) do_op($sformatf("vec%0d", i), vecs[i]);

      // Start pulse while busy must not disturb 100/9
      @(negedge clk);
      start_op(100, 9);
      lat = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (k == 2) begin
            start = 1'b1; dividend = 8'd50; divisor = 8'd5;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            lat = k;
            break;
         end
      end
      start = 1'b0;
      check("ignored-start latency", lat, W + 1);
      check("ignored-start quotient", int'(quotient), 11);
      check("ignored-start remainder", int'(remainder), 1);
      check("ignored-start div_by_zero", int'(div_by_zero), 0);
      prev_q = 11; prev_r = 1;

      // Reset mid-run aborts with no partial result and no done
      @(negedge clk);
      start_op(200, 7);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort busy", int'(busy), 0);
      check("abort done", int'(done), 0);
      check("abort quotient", int'(quotient), 0);
      check("abort remainder", int'(remainder), 0);
      check("abort div_by_zero", int'(div_by_zero), 0);
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      check("abort no done/busy after reset", ndone, 0);
      prev_q = 0; prev_r = 0;
      do_op("after-abort 17/4", vecs[9]);

      // Back-to-back: second start issued in the DONE cycle of the first
      @(negedge clk);
      start_op(200, 7);
      wait_done(prev_q, prev_r, lat, nb, nchg);
      check("b2b first latency", lat, W + 1);
      check("b2b first quotient", int'(quotient), 28);
      start = 1'b1; dividend = 8'd81; divisor = 8'd9;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(28, 4, lat, nb, nchg);
      check("b2b second latency", lat, W + 1);
      check("b2b second busy cycles", nb, W);
      check("b2b first result held", nchg, 0);
      check("b2b second quotient", int'(quotient), 9);
      check("b2b second remainder", int'(remainder), 0);
      check("b2b second div_by_zero", int'(div_by_zero), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
